// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// The key legend table is used only when KEYPAD_HEX_MAP_EN is defined.
package keypad_pkg;

   localparam int ROW_W = 4;
   localparam int COL_W = 4;
   localparam int IDX_W = 2;
   localparam int KEY_W = 4;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // Printed legend indexed [row][col]; outer pattern lists row3 first, inner lists col3 first
   localparam logic [ROW_W-1:0][COL_W-1:0][KEY_W-1:0] HEX_MAP = '{
      '{4'hD, 4'hF, 4'h0, 4'hE},
      '{4'hC, 4'h9, 4'h8, 4'h7},
      '{4'hB, 4'h6, 4'h5, 4'h4},
      '{4'hA, 4'h3, 4'h2, 4'h1}
   };

   function automatic logic [IDX_W-1:0] first_low(input logic [ROW_W-1:0] rows);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = ROW_W - 1; i >= 0; i--) begin
         if (!rows[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [KEY_W-1:0] hex_key(input logic [IDX_W-1:0] row,
                                                input logic [IDX_W-1:0] col);
      return HEX_MAP[row][col];
   endfunction

endpackage

// File: rtl/keypad_counter.sv
// Saturating up-counter shared by the scan dwell, press debounce and release debounce.
// Clear has priority over enable; the count stops at the terminal value instead of wrapping.
module keypad_counter #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   assign tc = (cnt == term);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !tc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a one-cycle accept pulse.
// Define KEYPAD_HEX_MAP_EN to report the printed legend instead of the raw {row,col} position.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 50000,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ROW_W-1:0] rows_s,
   output logic [COL_W-1:0] cols,
   output logic [KEY_W-1:0] key,
   output logic             key_valid,
   output logic             key_held
);

   localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SCAN_TERM = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] col_q, col_d;
   logic [IDX_W-1:0] row_q, row_d;
   logic [KEY_W-1:0] key_d;
   logic             kv_d, kh_d;
   logic             cnt_clr, cnt_en, tc;
   logic [CNT_W-1:0] term;
   logic             any_low, row_low;

   keypad_counter #(
      .CNT_W(CNT_W)
   ) u_counter (
      .clk  (clk),
      .reset(reset),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .term (term),
      .tc   (tc)
   );

   assign cols    = ~(COL_W'(1) << col_q);
   assign any_low = (rows_s != '1);
   assign row_low = !rows_s[row_q];

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      key_d   = key;
      kv_d    = 1'b0;
      kh_d    = key_held;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      term    = (state_q == SCAN) ? SCAN_TERM : DEB_TERM;

      case (state_q)
         SCAN: begin
            if (tc) begin
               cnt_clr = 1'b1;
               if (any_low) begin
                  row_d   = first_low(rows_s);
                  state_d = DEBOUNCE;
               end else begin
                  col_d = col_q + IDX_W'(1);
               end
            end else begin
               cnt_en = 1'b1;
            end
         end
         DEBOUNCE: begin
            if (!row_low) begin
               cnt_clr = 1'b1;
               col_d   = col_q + IDX_W'(1);
               state_d = SCAN;
            end else if (tc) begin
               cnt_clr = 1'b1;
               kv_d    = 1'b1;
               kh_d    = 1'b1;
`ifdef KEYPAD_HEX_MAP_EN
               key_d   = hex_key(row_q, col_q);
`else
               key_d   = {row_q, col_q};
`endif
               state_d = HELD;
            end else begin
               cnt_en = 1'b1;
            end
         end
         HELD: begin
            // Other rows are ignored here, so a second key on the same column cannot re-trigger
            if (!row_low) begin
               cnt_clr = 1'b1;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (row_low) begin
               cnt_clr = 1'b1;
            end else if (tc) begin
               cnt_clr = 1'b1;
               kh_d    = 1'b0;
               col_d   = col_q + IDX_W'(1);
               state_d = SCAN;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: begin
            cnt_clr = 1'b1;
            state_d = SCAN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SCAN;
         col_q     <= '0;
         row_q     <= '0;
         key       <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         key       <= key_d;
         key_valid <= kv_d;
         key_held  <= kh_d;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and an expected-key queue.
// Build with KEYPAD_HEX_MAP_EN defined to check the legend-mapped key codes.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  rows_s;
   logic [3:0]  cols;
   logic [3:0]  key;
   logic        key_valid;
   logic        key_held;

   logic [15:0] pressed;
   logic [3:0]  exp_q[$];
   logic        prev_kv;
   int          total;
   int          bad;
   int          pulses;

`ifdef KEYPAD_HEX_MAP_EN
   localparam logic [3:0] LEGEND [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };
`endif

   keypad_scanner #(
      .SCAN_CYCLES    (4),
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rows_s   (rows_s),
      .cols     (cols),
      .key      (key),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   always #5 clk = ~clk;

   // Passive matrix: a row reads low when a pressed key sits on the currently driven column
   always_comb begin
      rows_s = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !cols[c]) rows_s[r] = 1'b0;
         end
      end
   end

   function automatic logic [15:0] kbit(input int r, input int c);
      return 16'(1) << (r * 4 + c);
   endfunction

   function automatic logic [3:0] exp_key(input int r, input int c);
`ifdef KEYPAD_HEX_MAP_EN
      return LEGEND[r][c];
`else
      return {r[1:0], c[1:0]};
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample 1 time unit later and score any accept pulse
   task automatic tick();
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) begin
         pulses++;
         check("kv_back_to_back", 32'(prev_kv), 32'd0);
         check("kv_queue_depth", 32'(exp_q.size()), 32'd1);
         if (exp_q.size() > 0) check("kv_key", 32'(key), 32'(exp_q.pop_front()));
      end
      prev_kv = key_valid;
   endtask

   task automatic release_and_check(input string tag, input logic [3:0] next_cols);
      pressed = '0;
      repeat (8) tick();
      check({tag, "_held_before"}, 32'(key_held), 32'd1);
      tick();
      check({tag, "_held_cleared"}, 32'(key_held), 32'd0);
      check({tag, "_next_col"}, 32'(cols), 32'(next_cols));
   endtask

   initial begin
      logic [3:0] one;
      logic [3:0] exp_cols;
      total   = 0;
      bad     = 0;
      pulses  = 0;
      prev_kv = 1'b0;
      one     = 4'b0001;
      pressed = '0;
      reset   = 1'b1;

      // Reset values, then idle column rotation
      repeat (2) tick();
      check("rst_cols", 32'(cols), 32'h0000000E);
      check("rst_key", 32'(key), 32'd0);
      check("rst_kv", 32'(key_valid), 32'd0);
      check("rst_held", 32'(key_held), 32'd0);
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_cols = ~(one << ((k / 4) % 4));
         check("idle_cols", 32'(cols), 32'(exp_cols));
      end

      // Clean press of row1/col2
      exp_q.push_back(exp_key(1, 2));
      pressed = kbit(1, 2);
      repeat (19) tick();
      check("p6_kv_early", 32'(key_valid), 32'd0);
      check("p6_cols_frozen", 32'(cols), 32'h0000000B);
      tick();
      check("p6_kv", 32'(key_valid), 32'd1);
      check("p6_held", 32'(key_held), 32'd1);
      tick();
      check("p6_kv_once", 32'(key_valid), 32'd0);
      release_and_check("p6_rel", 4'b0111);

      // Bounce on row0/col0: three low samples, one high, then stable low
      exp_q.push_back(exp_key(0, 0));
      pressed = kbit(0, 0);
      repeat (10) tick();
      pressed = '0;
      tick();
      check("b_abort_cols", 32'(cols), 32'h0000000D);
      check("b_abort_held", 32'(key_held), 32'd0);
      pressed = kbit(0, 0);
      repeat (23) tick();
      check("b_kv_early", 32'(key_valid), 32'd0);
      tick();
      check("b_kv", 32'(key_valid), 32'd1);
      check("b_held", 32'(key_held), 32'd1);
      release_and_check("b_rel", 4'b1101);

      // Hold row3/col1, add row2/col1, then release both with a bounce
      exp_q.push_back(exp_key(3, 1));
      pressed = kbit(3, 1);
      repeat (11) tick();
      check("h_kv_early", 32'(key_valid), 32'd0);
      tick();
      check("h_kv", 32'(key_valid), 32'd1);
      pressed = kbit(3, 1) | kbit(2, 1);
      repeat (10) tick();
      check("h_two_held", 32'(key_held), 32'd1);
      check("h_key_kept", 32'(key), 32'(exp_key(3, 1)));
      pressed = '0;
      repeat (2) tick();
      pressed = kbit(3, 1);
      repeat (2) tick();
      pressed = '0;
      repeat (7) tick();
      check("h_held_7highs", 32'(key_held), 32'd1);
      tick();
      check("h_held_8highs", 32'(key_held), 32'd0);
      check("h_next_col", 32'(cols), 32'h0000000B);

      // Reset in the middle of a debounce
      pressed = kbit(1, 2);
      repeat (9) tick();
      check("r_mid_kv", 32'(key_valid), 32'd0);
      check("r_mid_cols", 32'(cols), 32'h0000000B);
      reset = 1'b1;
      tick();
      check("r_cols", 32'(cols), 32'h0000000E);
      check("r_key", 32'(key), 32'd0);
      check("r_kv", 32'(key_valid), 32'd0);
      check("r_held", 32'(key_held), 32'd0);
      reset   = 1'b0;
      pressed = '0;
      repeat (20) tick();

      check("pulse_count", 32'(pulses), 32'd3);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
